// File: rtl/ctrl_decode_pkg.sv
// Shared types and helpers for the sequenced control decoder.
// CTRL_DECODE_PARITY_EN adds a stored even-parity bit to every table entry.
package ctrl_decode_pkg;

  localparam int DEF_OP_W      = 5;
  localparam int DEF_CW_W      = 26;
  localparam int DEF_MAX_STEPS = 4;

  function automatic int step_w_of(input int max_steps);
    return (max_steps < 2) ? 1 : $clog2(max_steps);
  endfunction

  localparam int DEF_STEP_W = step_w_of(DEF_MAX_STEPS);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_e;

  // Table entry layout for the default configuration.
  typedef struct packed {
    logic [DEF_CW_W-1:0]   cw;
    logic [DEF_STEP_W-1:0] steps;
`ifdef CTRL_DECODE_PARITY_EN
    logic                  par;
`endif
  } entry_t;

  function automatic logic even_par(input logic [63:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/ctrl_decode_table.sv
// Opcode-indexed table: synchronous write/clear, combinational read.
// With CTRL_DECODE_PARITY_EN each row also keeps an even-parity bit that is rechecked on read.
module ctrl_decode_table
  import ctrl_decode_pkg::*;
#(
  parameter int OP_W   = DEF_OP_W,
  parameter int CW_W   = DEF_CW_W,
  parameter int STEP_W = DEF_STEP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [OP_W-1:0]   wr_addr_i,
  input  logic [CW_W-1:0]   wr_cw_i,
  input  logic [STEP_W-1:0] wr_steps_i,
  input  logic [OP_W-1:0]   rd_addr_i,
  output logic [CW_W-1:0]   rd_cw_o,
  output logic [STEP_W-1:0] rd_steps_o,
  output logic              rd_err_o
);

  localparam int ENTRIES = 2 ** OP_W;

  logic [CW_W-1:0]   cw_q    [ENTRIES];
  logic [STEP_W-1:0] steps_q [ENTRIES];

  // Row storage; reset clears every entry to cw=0, steps=0.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        cw_q[i]    <= '0;
        steps_q[i] <= '0;
      end
    end else if (we_i) begin
      cw_q[wr_addr_i]    <= wr_cw_i;
      steps_q[wr_addr_i] <= wr_steps_i;
    end
  end

  assign rd_cw_o    = cw_q[rd_addr_i];
  assign rd_steps_o = steps_q[rd_addr_i];

`ifdef CTRL_DECODE_PARITY_EN
  logic [ENTRIES-1:0] par_q;

  // Parity bits; all-zero rows have zero parity, so clearing stays consistent.
  always_ff @(posedge clk) begin
    if (rst) begin
      par_q <= '0;
    end else if (we_i) begin
      par_q[wr_addr_i] <= even_par(64'({wr_cw_i, wr_steps_i}));
    end
  end

  assign rd_err_o = even_par(64'({rd_cw_o, rd_steps_o})) ^ par_q[rd_addr_i];
`else
  assign rd_err_o = 1'b0;
`endif

endmodule

// File: rtl/ctrl_decode_seq.sv
// Sequenced control decoder: opcode -> 1..MAX_STEPS registered control words.
// Optional table parity checking is enabled with CTRL_DECODE_PARITY_EN.
module ctrl_decode_seq
  import ctrl_decode_pkg::*;
#(
  parameter int  OP_W      = DEF_OP_W,
  parameter int  CW_W      = DEF_CW_W,
  parameter int  MAX_STEPS = DEF_MAX_STEPS,
  localparam int STEP_W    = step_w_of(MAX_STEPS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_op,
  input  logic              cfg_we,
  input  logic [OP_W-1:0]   cfg_addr,
  input  logic [CW_W-1:0]   cfg_cw,
  input  logic [STEP_W-1:0] cfg_steps,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CW_W-1:0]   out_cw,
  output logic [OP_W-1:0]   out_op,
  output logic [STEP_W-1:0] out_step,
  output logic              out_last,
  output logic              err_parity
);

  state_e            state_q, state_d;
  logic [CW_W-1:0]   cw_q, cw_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [STEP_W-1:0] steps_q, steps_d;
  logic              last_q, last_d;
  logic              err_q, err_d;

  logic [CW_W-1:0]   rd_cw;
  logic [STEP_W-1:0] rd_steps;
  logic              rd_err;
  logic              accept;

  ctrl_decode_table #(
    .OP_W   (OP_W),
    .CW_W   (CW_W),
    .STEP_W (STEP_W)
  ) u_table (
    .clk        (clk),
    .rst        (rst),
    .we_i       (cfg_we),
    .wr_addr_i  (cfg_addr),
    .wr_cw_i    (cfg_cw),
    .wr_steps_i (cfg_steps),
    .rd_addr_i  (in_op),
    .rd_cw_o    (rd_cw),
    .rd_steps_o (rd_steps),
    .rd_err_o   (rd_err)
  );

  // Accepting on the final handshake lets the next opcode follow without a bubble.
  assign in_ready = (state_q == IDLE) | ((state_q == ISSUE) & last_q & out_ready);
  assign accept   = in_valid & in_ready;

  // Next-state, step sequencing and entry latch.
  always_comb begin
    state_d = state_q;
    cw_d    = cw_q;
    op_d    = op_q;
    step_d  = step_q;
    steps_d = steps_q;
    last_d  = last_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        state_d = accept ? ISSUE : IDLE;
      end
      ISSUE: begin
        if (!out_ready) begin
          state_d = ISSUE;
        end else if (!last_q) begin
          state_d = ISSUE;
          step_d  = step_q + STEP_W'(1);
          last_d  = ((step_q + STEP_W'(1)) == steps_q);
        end else begin
          state_d = in_valid ? ISSUE : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A corrupt entry still runs its full length, but with a zeroed control word.
    if (accept) begin
      cw_d    = rd_err ? '0 : rd_cw;
      op_d    = in_op;
      step_d  = '0;
      steps_d = rd_steps;
      last_d  = (rd_steps == '0);
      err_d   = rd_err;
    end else begin
      err_d   = err_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cw_q    <= '0;
      op_q    <= '0;
      step_q  <= '0;
      steps_q <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cw_q    <= cw_d;
      op_q    <= op_d;
      step_q  <= step_d;
      steps_q <= steps_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  assign out_valid  = (state_q == ISSUE);
  assign out_cw     = cw_q;
  assign out_op     = op_q;
  assign out_step   = step_q;
  assign out_last   = last_q;
  assign err_parity = err_q;

endmodule

// File: tb/tb_ctrl_decode_seq.sv
// Directed self-checking bench for ctrl_decode_seq (default parameters).
// The parity scenario is compiled in only when CTRL_DECODE_PARITY_EN is defined.
module tb_ctrl_decode_seq;

  localparam logic [25:0] CW5  = 26'h2AAAAAA;
  localparam logic [25:0] CW1  = 26'h1234567;
  localparam logic [25:0] CW7A = 26'h0000ABC;
  localparam logic [25:0] CW7B = 26'h3FFFFFF;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_op;
  logic        cfg_we;
  logic [4:0]  cfg_addr;
  logic [25:0] cfg_cw;
  logic [1:0]  cfg_steps;
  logic        out_valid;
  logic        out_ready;
  logic [25:0] out_cw;
  logic [4:0]  out_op;
  logic [1:0]  out_step;
  logic        out_last;
  logic        err_parity;

  int          n_tests;
  int          n_fail;
  logic [34:0] exp_v;
  wire  [34:0] obs = {out_valid, out_cw, out_op, out_step, out_last};

  ctrl_decode_seq dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_cw     (cfg_cw),
    .cfg_steps  (cfg_steps),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_cw     (out_cw),
    .out_op     (out_op),
    .out_step   (out_step),
    .out_last   (out_last),
    .err_parity (err_parity)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input logic [4:0] a, input logic [25:0] cw, input logic [1:0] st);
    cfg_we = 1'b1; cfg_addr = a; cfg_cw = cw; cfg_steps = st;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    exp_v = 35'h0;
    if (obs !== exp_v) begin n_fail++; $display("FAIL reset_outputs got %h exp %h", obs, exp_v); end
    n_tests++;
    rst = 1'b0;
    tick();
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    n_tests++;
    if (err_parity !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", err_parity); end
    n_tests++;
  endtask

  task automatic test_unwritten();
    in_valid = 1'b1; in_op = 5'd3;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL idle_ready got %b exp 1", in_ready); end
    n_tests++;
    tick();
    in_valid = 1'b0;
    exp_v = {1'b1, 26'h0, 5'd3, 2'd0, 1'b1};
    if (obs !== exp_v) begin n_fail++; $display("FAIL unwritten_word got %h exp %h", obs, exp_v); end
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL unwritten_ready got %b exp 1", in_ready); end
    n_tests++;
    tick();
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL unwritten_idle got %b exp 0", out_valid); end
    n_tests++;
  endtask

  task automatic test_multi_step();
    write_entry(5'd5, CW5, 2'd2);
    in_valid = 1'b1; in_op = 5'd5;
    tick();
    in_valid = 1'b0;
    for (int s = 0; s < 3; s++) begin
      exp_v = {1'b1, CW5, 5'd5, 2'(s), (s == 2)};
      if (obs !== exp_v) begin n_fail++; $display("FAIL multi_step%0d got %h exp %h", s, obs, exp_v); end
      n_tests++;
      if (err_parity !== 1'b0) begin n_fail++; $display("FAIL multi_err%0d got %b exp 0", s, err_parity); end
      n_tests++;
      tick();
    end
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL multi_end got %b exp 0", out_valid); end
    n_tests++;
  endtask

  task automatic test_back_to_back();
    write_entry(5'd1, CW1, 2'd0);
    in_valid = 1'b1; in_op = 5'd5;
    tick();
    in_op = 5'd1;
    for (int s = 0; s < 3; s++) begin
      exp_v = {1'b1, CW5, 5'd5, 2'(s), (s == 2)};
      if (obs !== exp_v) begin n_fail++; $display("FAIL b2b_step%0d got %h exp %h", s, obs, exp_v); end
      n_tests++;
      if (in_ready !== (s == 2)) begin n_fail++; $display("FAIL b2b_ready%0d got %b exp %b", s, in_ready, (s == 2)); end
      n_tests++;
      tick();
    end
    in_valid = 1'b0;
    exp_v = {1'b1, CW1, 5'd1, 2'd0, 1'b1};
    if (obs !== exp_v) begin n_fail++; $display("FAIL b2b_next got %h exp %h", obs, exp_v); end
    n_tests++;
    tick();
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_end got %b exp 0", out_valid); end
    n_tests++;
  endtask

  task automatic test_stall();
    in_valid = 1'b1; in_op = 5'd5;
    tick();
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    exp_v = {1'b1, CW5, 5'd5, 2'd1, 1'b0};
    for (int k = 0; k < 4; k++) begin
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready%0d got %b exp 0", k, in_ready); end
      n_tests++;
      tick();
      if (obs !== exp_v) begin n_fail++; $display("FAIL stall_hold%0d got %h exp %h", k, obs, exp_v); end
      n_tests++;
    end
    out_ready = 1'b1;
    tick();
    exp_v = {1'b1, CW5, 5'd5, 2'd2, 1'b1};
    if (obs !== exp_v) begin n_fail++; $display("FAIL stall_release got %h exp %h", obs, exp_v); end
    n_tests++;
    out_ready = 1'b0;
    #1;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_last_ready got %b exp 0", in_ready); end
    n_tests++;
    out_ready = 1'b1;
    #1;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL last_ready got %b exp 1", in_ready); end
    n_tests++;
    tick();
  endtask

  task automatic test_write_collision();
    write_entry(5'd7, CW7A, 2'd1);
    in_valid = 1'b1; in_op = 5'd7;
    cfg_we = 1'b1; cfg_addr = 5'd7; cfg_cw = 26'h0000155; cfg_steps = 2'd3;
    tick();
    in_valid = 1'b0;
    exp_v = {1'b1, CW7A, 5'd7, 2'd0, 1'b0};
    if (obs !== exp_v) begin n_fail++; $display("FAIL collide_old got %h exp %h", obs, exp_v); end
    n_tests++;
    cfg_cw = CW7B; cfg_steps = 2'd0;
    tick();
    cfg_we = 1'b0;
    exp_v = {1'b1, CW7A, 5'd7, 2'd1, 1'b1};
    if (obs !== exp_v) begin n_fail++; $display("FAIL inflight_kept got %h exp %h", obs, exp_v); end
    n_tests++;
    tick();
    in_valid = 1'b1; in_op = 5'd7;
    tick();
    in_valid = 1'b0;
    exp_v = {1'b1, CW7B, 5'd7, 2'd0, 1'b1};
    if (obs !== exp_v) begin n_fail++; $display("FAIL rewrite_new got %h exp %h", obs, exp_v); end
    n_tests++;
    tick();
  endtask

`ifdef CTRL_DECODE_PARITY_EN
  task automatic test_parity();
    logic [31:0] par_v;
    write_entry(5'd9, 26'h0F0F0F0, 2'd1);
    par_v = dut.u_table.par_q;
    par_v[9] = ~par_v[9];
    force dut.u_table.par_q = par_v;
    in_valid = 1'b1; in_op = 5'd9;
    tick();
    in_valid = 1'b0;
    for (int s = 0; s < 2; s++) begin
      exp_v = {1'b1, 26'h0, 5'd9, 2'(s), (s == 1)};
      if (obs !== exp_v) begin n_fail++; $display("FAIL parity_word%0d got %h exp %h", s, obs, exp_v); end
      n_tests++;
      if (err_parity !== 1'b1) begin n_fail++; $display("FAIL parity_err%0d got %b exp 1", s, err_parity); end
      n_tests++;
      tick();
    end
    release dut.u_table.par_q;
    in_valid = 1'b1; in_op = 5'd1;
    tick();
    in_valid = 1'b0;
    if (err_parity !== 1'b0) begin n_fail++; $display("FAIL parity_clear got %b exp 0", err_parity); end
    n_tests++;
    if (out_cw !== CW1) begin n_fail++; $display("FAIL parity_clean_cw got %h exp %h", out_cw, CW1); end
    n_tests++;
    tick();
  endtask
`endif

  task automatic test_reset_mid();
    in_valid = 1'b1; in_op = 5'd5;
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    exp_v = 35'h0;
    if (obs !== exp_v) begin n_fail++; $display("FAIL midreset_outputs got %h exp %h", obs, exp_v); end
    n_tests++;
    rst = 1'b0;
    tick();
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_quiet got %b exp 0", out_valid); end
    n_tests++;
    in_valid = 1'b1; in_op = 5'd5;
    tick();
    in_valid = 1'b0;
    exp_v = {1'b1, 26'h0, 5'd5, 2'd0, 1'b1};
    if (obs !== exp_v) begin n_fail++; $display("FAIL midreset_cleared got %h exp %h", obs, exp_v); end
    n_tests++;
    tick();
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_op     = 5'd0;
    cfg_we    = 1'b0;
    cfg_addr  = 5'd0;
    cfg_cw    = 26'h0;
    cfg_steps = 2'd0;
    out_ready = 1'b1;
    test_reset();
    test_unwritten();
    test_multi_step();
    test_back_to_back();
    test_stall();
    test_write_collision();
`ifdef CTRL_DECODE_PARITY_EN
    test_parity();
`endif
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ctrl_decode_seq.md
Name: ctrl_decode_seq

Overview:
- Sequenced, parametrised successor to the flat combinational control decoder.
- Maps an OP_W-bit opcode to a CW_W-bit control word through a run-time programmable table.
- Each table entry may expand into 1..MAX_STEPS consecutive control words.
- Sits between the instruction front-end (valid/ready) and the datapath control sinks (valid/ready), with a registered output.

Parameters:
- OP_W, 5, opcode width; table depth is 2**OP_W.
- CW_W, 26, control-word width.
- MAX_STEPS, 4, maximum words per opcode; must be a power of two and ≥2. STEP_W = clog2(MAX_STEPS).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  opcode valid
- in_ready  out  1  opcode accepted when in_valid & in_ready
- in_op  in  OP_W  opcode
- cfg_we  in  1  table write strobe
- cfg_addr  in  OP_W  table entry index
- cfg_cw  in  CW_W  control word to store
- cfg_steps  in  STEP_W  step count minus one
- out_valid  out  1  control word valid
- out_ready  in  1  sink accepts
- out_cw  out  CW_W  control word
- out_op  out  OP_W  echo of the accepted opcode
- out_step  out  STEP_W  current step index
- out_last  out  1  final step of this opcode
- err_parity  out  1  table parity error flag; 0 unless the macro is enabled

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset:
  - All table entries cleared to cw=0, steps=0.
  - FSM to IDLE.
  - out_valid, out_cw, out_op, out_step, out_last and err_parity all 0.
  - in_ready is 1 in the first cycle after reset deasserts.
- Table:
  - cfg_we writes {cfg_cw, cfg_steps} at cfg_addr on the clock edge.
  - An opcode accepted in the same cycle as a write to the same address uses the OLD contents.
  - An accepted opcode latches its entry, so later writes never affect an in-flight sequence.
- FSM states: IDLE, ISSUE.
  - IDLE: out_valid=0, in_ready=1. On accept, latch the entry and go to ISSUE with out_step=0.
  - ISSUE: out_valid=1. When out_valid & out_ready and not last, out_step increments.
  - ISSUE, final handshake (out_last & out_ready): if in_valid, accept the next opcode in the same cycle and stay in ISSUE with step 0 (no bubble); otherwise go to IDLE.
- in_ready = IDLE | (ISSUE & out_last & out_ready); combinational from state and out_ready only.
- Latency: accept at cycle t gives step 0 valid at t+1. An N-step opcode with out_ready held high occupies cycles t+1..t+N.
- out_last = (out_step == latched steps).
- Stall: while out_valid & ~out_ready, every out_* signal holds stable.
- Step counter never wraps; it ends at the latched steps value.
- Reset mid-sequence aborts the sequence with no further outputs; table contents are cleared.

Optional Feature:
- Macro: CTRL_DECODE_PARITY_EN.
- Defined:
  - Each entry stores an even-parity bit over {cw, steps}, computed at write.
  - On accept, parity is rechecked. On mismatch, err_parity=1 alongside every step of that opcode, and out_cw is forced to 0 for all of its steps.
  - Step count, handshakes and out_last are unchanged.
  - err_parity clears when the next opcode is accepted or on reset.
- Undefined: no parity storage; err_parity tied to 0.

Decomposition:
- Package ctrl_decode_pkg:
  - state enum {IDLE, ISSUE}
  - entry struct {cw, steps[, par]}
  - function clog2-derived STEP_W
  - parity function
- Sub-module ctrl_decode_table: 2**OP_W-entry register file with synchronous write, synchronous clear and combinational read port, plus optional parity generation/check.
- FSM, step counter and output registers live in the top module.

Test Plan:
- Reset, then opcode 3 with an unwritten table, out_ready=1 → one word: cw=0, step=0, out_last=1, out_op=3; in_ready back to 1.
- Write op 5 = {cw=26'h2AAAAAA, steps=2}, then issue op 5 with out_ready=1 → three consecutive words, steps 0,1,2; out_last only on step 2; no gaps.
- Op 5 followed immediately by op 1 (steps=0), in_valid held high → op 1 step 0 appears the cycle after op 5 step 2; no bubble.
- Hold out_ready=0 for 4 cycles on op 5 step 1 → out_cw, out_step, out_last stable; in_ready=0 throughout; step 2 follows release.
- Write op 7 in the same cycle op 7 is accepted → old contents emitted. Rewrite op 7 mid-sequence → the current sequence is unchanged and the next issue uses the new contents.
- CTRL_DECODE_PARITY_EN: force a bit flip in a table entry via bench backdoor, then issue that opcode → err_parity=1 and cw=0 on every step; a clean opcode afterwards → err_parity=0.
